// File: rtl/jk_down_counter.sv
// ----------------------------------------------------------------------------
// jk_down_counter
//   Synchronous binary down counter built from WIDTH JK flip-flop stages.
//   Supports parallel load (priority over count), count enable, wrap or
//   saturate-at-zero, and a registered one-cycle borrow pulse on wrap.
//
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset (q=0, qc=all ones, borrow=0)
//   en            count enable, decrement by one per enabled edge
//   load          synchronous parallel load of d, overrides en
//   d             load value
//   hold_at_zero  1: saturate at 0, 0: wrap 0 -> 2^WIDTH-1
//   q             counter value (registered)
//   qc            complement of q (registered, always ~q)
//   zero          combinational, high when q == 0
//   borrow        registered pulse for the cycle after a wrap
// ----------------------------------------------------------------------------
module jk_down_counter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic             hold_at_zero,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qc,
    output logic             zero,
    output logic             borrow
);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] qc_q;
    logic             borrow_q, borrow_d;
    logic [WIDTH-1:0] low_zero;   // low_zero[i]: bits below i are all 0
    logic [WIDTH-1:0] t;
    logic [WIDTH-1:0] j, k;
    logic             stall;

    assign zero = (cnt_q == '0);

    // Saturating at zero blocks the whole toggle chain, which would
    // otherwise flip every stage and wrap to all ones.
    assign stall = zero & hold_at_zero;

    always_comb begin
        low_zero    = '0;
        low_zero[0] = 1'b1;
        for (int i = 1; i < WIDTH; i++) begin
            low_zero[i] = low_zero[i-1] & ~cnt_q[i-1];
        end
    end

    assign t = {WIDTH{en & ~stall}} & low_zero;

    // Per-stage JK inputs: load forces J=d, K=~d; count uses J=K=T.
    always_comb begin
        j = t;
        k = t;
        if (load) begin
            j = d;
            k = ~d;
        end
    end

    // JK characteristic equation applied bitwise.
    assign cnt_d    = (j & ~cnt_q) | (~k & cnt_q);
    assign borrow_d = ~load & en & zero & ~hold_at_zero;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            qc_q     <= '1;
            borrow_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            qc_q     <= ~cnt_d;
            borrow_q <= borrow_d;
        end
    end

    assign q      = cnt_q;
    assign qc     = qc_q;
    assign borrow = borrow_q;

endmodule
